intersection_phase_arbiter: RTL and testbench
=============================================

INTERSECTION_PHASE_ARBITER -- requirements
Module: intersection_phase_arbiter

Interface
REQ-001 Parameter GREEN_MIN, default 4, minimum green dwell in clk cycles (1..15).
REQ-002 Parameter GREEN_MAX, default 8, green dwell after which a pending competing request is served (GREEN_MIN..15).
REQ-003 Parameter YELLOW, default 2, yellow dwell in cycles (1..15).
REQ-004 Parameter ALL_RED, default 1, all-red clearance dwell in cycles (1..15).
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req  input  4  level-sensitive approach requests; bit0 M1, bit1 M2, bit2 MT, bit3 S.
REQ-008 emg_req  input  1  emergency preemption request, level-sensitive.
REQ-009 emg_dir  input  2  approach index (0=M1, 1=M2, 2=MT, 3=S) to preempt for; sampled only with emg_req high.
REQ-010 light_M1, light_M2, light_MT, light_S  output  3 each  lamp drive: 001 green, 010 yellow, 100 red.
REQ-011 gnt  output  2  index of the approach currently holding green or yellow.
REQ-012 phase  output  2  state: 0 IDLE, 1 GREEN, 2 YELLOW, 3 ALL_RED.

Function
REQ-013 Outputs SHALL be registered and SHALL update on the same edge as the state register.
REQ-014 In every state, every non-granted approach SHALL show 100.
REQ-015 IDLE: all four lights SHALL be 100.
REQ-016 IDLE, emg_req high at an edge: SHALL move to GREEN with gnt=emg_dir, timer=0.
REQ-017 IDLE, req nonzero and emg_req low at an edge: SHALL move to GREEN with gnt = round-robin winner, timer=0.
REQ-018 IDLE, no request: SHALL remain in IDLE.
REQ-019 Round-robin: search order SHALL be last_gnt+1, +2, +3, +4 (mod 4); the first set req bit wins; last_gnt SHALL update on each entry to GREEN.
REQ-020 Each phase SHALL use a 4-bit timer: 0 on state entry, +1 per cycle, saturating at 15; a dwell of D cycles ends on the edge where timer == D-1.
REQ-021 GREEN: light[gnt]=001.
REQ-022 GREEN, competing request (any req bit other than gnt): SHALL go to YELLOW at the edge where timer ≥ GREEN_MAX-1, and never before timer == GREEN_MIN-1.
REQ-023 GREEN, no competing request and req[gnt] high: SHALL rest in GREEN indefinitely.
REQ-024 GREEN, no competing request and req[gnt] low after timer ≥ GREEN_MIN-1: SHALL go to YELLOW.
REQ-025 GREEN, emg_req high and emg_dir != gnt: SHALL go to YELLOW at the next edge, ignoring GREEN_MIN.
REQ-026 GREEN, emg_req high and emg_dir == gnt: SHALL hold GREEN while emg_req stays high, overriding REQ-022.
REQ-027 YELLOW: light[gnt]=010; SHALL last exactly YELLOW cycles, then ALL_RED; emg_req SHALL NOT shorten it.
REQ-028 ALL_RED: all lights 100; SHALL last exactly ALL_RED cycles.
REQ-029 ALL_RED exit priority: emg_req → GREEN with gnt=emg_dir; else req nonzero → GREEN with round-robin winner; else IDLE.
REQ-030 Entering GREEN from ALL_RED for the same approach just released is legal (single requester).
REQ-031 A green SHALL never be shown directly after another approach's green; the sequence SHALL always pass through YELLOW and ALL_RED.
REQ-032 emg_dir changing while in GREEN for the emergency approach SHALL be treated as REQ-025.

Reset
REQ-033 rst high SHALL immediately force: phase=IDLE, timer=0, gnt=0, last_gnt=3, all lights=100, including mid-GREEN or mid-YELLOW.
REQ-034 After rst deasserts, the first grant with all req bits set SHALL go to M1.

Verification
REQ-035 Defaults, reset then req=0001 held: M1 green 1 cycle after the first edge and rests green; with req=0000, no yellow before 4 green cycles total.
REQ-036 req=1111 held: gnt sequence 0,1,2,3,0; each green 8 cycles, yellow 2, all-red 1; cycle period 11 per approach.
REQ-037 M1 green at timer=1, assert emg_req with emg_dir=3: yellow on the next edge (2 cycles), all-red 1 cycle, then S green held while emg_req stays high despite req=0111.
REQ-038 req=0010 only: M2 green, drop req at timer=6: yellow, all-red, then IDLE with all 100.
REQ-039 Assert rst during YELLOW: all lights 100 and phase=0 without waiting for a clk edge; then req=1111 grants M1 first.
REQ-040 Every cycle, the bench checks REQ-014 and REQ-031: at most one light shows non-100, and no green follows a different approach's green without an intervening yellow and all-red.

Source files
------------

// File: rtl/intersection_phase_arbiter.sv
// Four-approach traffic phase arbiter: round-robin green service with min/max
// dwell, yellow and all-red clearance, and emergency preemption.
module intersection_phase_arbiter #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW    = 2,
  parameter int ALL_RED   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       emg_req,
  input  logic [1:0] emg_dir,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic [1:0] gnt,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_ALL_RED = 2'd3
  } state_t;

  localparam logic [3:0] GMIN_T = 4'(GREEN_MIN - 1);
  localparam logic [3:0] GMAX_T = 4'(GREEN_MAX - 1);
  localparam logic [3:0] YEL_T  = 4'(YELLOW - 1);
  localparam logic [3:0] AR_T   = 4'(ALL_RED - 1);

  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_RED    = 3'b100;

  state_t          state, state_n;
  logic [3:0]      timer, timer_n;
  logic [1:0]      gnt_q, gnt_n;
  logic [1:0]      last_gnt, last_n;
  logic [3:0][2:0] lights_q, lights_n;
  logic [1:0]      rr_win;
  logic            rr_hit;
  logic [1:0]      rr_idx;
  logic            competing;

  // Round-robin search starting just after the last served approach.
  always_comb begin
    rr_win = last_gnt;
    rr_hit = 1'b0;
    rr_idx = last_gnt;
    for (int k = 1; k <= 4; k++) begin
      rr_idx = last_gnt + k[1:0];
      if (!rr_hit && req[rr_idx]) begin
        rr_win = rr_idx;
        rr_hit = 1'b1;
      end
    end
  end

  assign competing = |(req & ~(4'b0001 << gnt_q));

  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    timer_n = (timer == 4'd15) ? timer : timer + 4'd1;
    case (state)
      ST_IDLE: begin
        if (emg_req) begin
          state_n = ST_GREEN;
          gnt_n   = emg_dir;
        end else if (|req) begin
          state_n = ST_GREEN;
          gnt_n   = rr_win;
        end
      end
      ST_GREEN: begin
        if (emg_req) begin
          if (emg_dir != gnt_q) state_n = ST_YELLOW;
        end else if (competing) begin
          if (timer >= GMAX_T) state_n = ST_YELLOW;
        end else if (!req[gnt_q] && timer >= GMIN_T) begin
          state_n = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (timer == YEL_T) state_n = ST_ALL_RED;
      end
      ST_ALL_RED: begin
        if (timer == AR_T) begin
          if (emg_req) begin
            state_n = ST_GREEN;
            gnt_n   = emg_dir;
          end else if (|req) begin
            state_n = ST_GREEN;
            gnt_n   = rr_win;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (state_n != state) timer_n = 4'd0;
  end

  assign last_n = (state_n == ST_GREEN && state != ST_GREEN) ? gnt_n : last_gnt;

  // Lamps are decoded from the next state so they flip on the same edge.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lights_n[i] = LT_RED;
      if (gnt_n == 2'(i)) begin
        if (state_n == ST_GREEN)  lights_n[i] = LT_GREEN;
        if (state_n == ST_YELLOW) lights_n[i] = LT_YELLOW;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= 4'd0;
      gnt_q    <= 2'd0;
      last_gnt <= 2'd3;
      lights_q <= {4{LT_RED}};
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      gnt_q    <= gnt_n;
      last_gnt <= last_n;
      lights_q <= lights_n;
    end
  end

  assign light_M1 = lights_q[0];
  assign light_M2 = lights_q[1];
  assign light_MT = lights_q[2];
  assign light_S  = lights_q[3];
  assign gnt      = gnt_q;
  assign phase    = state;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Directed bench for intersection_phase_arbiter with a per-cycle expectation
// queue and a free-running lamp-safety monitor.
module tb_intersection_phase_arbiter;

  localparam logic [1:0] P_IDLE = 2'd0, P_GREEN = 2'd1, P_YEL = 2'd2, P_AR = 2'd3;

  logic       clk, rst, emg_req;
  logic [3:0] req;
  logic [1:0] emg_dir, gnt, phase;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic [3:0][2:0] lt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] ph;
    logic [1:0] g;
    string      tag;
  } exp_t;

  exp_t sb[$];

  intersection_phase_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .emg_req(emg_req), .emg_dir(emg_dir),
    .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
    .gnt(gnt), .phase(phase)
  );

  assign lt = {light_S, light_MT, light_M2, light_M1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] exp_lights(logic [1:0] ph, logic [1:0] g);
    logic [11:0] l;
    l = 12'h924;
    if (ph == P_GREEN) l[g*3 +: 3] = 3'b001;
    if (ph == P_YEL)   l[g*3 +: 3] = 3'b010;
    return l;
  endfunction

  function automatic int nonred(logic [3:0][2:0] l);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (l[i] !== 3'b100) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock: drive inputs, queue the expected post-edge state, then compare.
  task automatic cyc(input logic [3:0] r, input logic e, input logic [1:0] d,
                     input logic [1:0] ph, input logic [1:0] g, input string tag);
    exp_t x;
    req = r; emg_req = e; emg_dir = d;
    x.ph = ph; x.g = g; x.tag = tag;
    sb.push_back(x);
    @(posedge clk); #1;
    x = sb.pop_front();
    chk({x.tag, "_phase"}, {10'd0, phase}, {10'd0, x.ph});
    chk({x.tag, "_lights"}, lt, exp_lights(x.ph, x.g));
    if (x.ph == P_GREEN || x.ph == P_YEL)
      chk({x.tag, "_gnt"}, {10'd0, gnt}, {10'd0, x.g});
  endtask

  // Safety monitor: one lit approach at most, and legal phase succession.
  initial begin
    logic [1:0] pph, pg;
    pph = P_IDLE; pg = 2'd0;
    forever begin
      @(negedge clk);
      total++;
      assert (nonred(lt) <= 1) else begin
        bad++; $error("FAIL mon_one_lit: observed %0d lit expected <=1", nonred(lt));
      end
      if (phase == P_GREEN && pph == P_GREEN) begin
        total++;
        assert (gnt === pg) else begin
          bad++; $error("FAIL mon_green_switch: observed gnt %0d expected %0d", gnt, pg);
        end
      end
      if (phase == P_GREEN && pph != P_GREEN) begin
        total++;
        assert (pph == P_IDLE || pph == P_AR) else begin
          bad++; $error("FAIL mon_green_entry: observed prev %0d expected 0 or 3", pph);
        end
      end
      if (phase == P_AR && pph != P_AR) begin
        total++;
        assert (pph == P_YEL) else begin
          bad++; $error("FAIL mon_allred_entry: observed prev %0d expected 2", pph);
        end
      end
      if (phase == P_YEL && pph != P_YEL) begin
        total++;
        assert (pph == P_GREEN && gnt === pg) else begin
          bad++; $error("FAIL mon_yellow_entry: observed prev %0d/%0d expected 1/%0d", pph, gnt, pg);
        end
      end
      pph = phase; pg = gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 4'd0; emg_req = 1'b0; emg_dir = 2'd0;
    @(posedge clk); #1;
    chk("reset_phase", {10'd0, phase}, {10'd0, P_IDLE});
    chk("reset_gnt", {10'd0, gnt}, 12'd0);
    chk("reset_lights", lt, 12'h924);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single requester on M1: grant, rest, release; then the minimum dwell.
    cyc(4'b0001, 0, 0, P_GREEN, 0, "m1_grant");
    repeat (12) cyc(4'b0001, 0, 0, P_GREEN, 0, "m1_rest");
    cyc(4'b0000, 0, 0, P_YEL, 0, "m1_release");
    cyc(4'b0000, 0, 0, P_YEL, 0, "m1_yel2");
    cyc(4'b0000, 0, 0, P_AR, 0, "m1_ar");
    cyc(4'b0000, 0, 0, P_IDLE, 0, "m1_idle");
    cyc(4'b0001, 0, 0, P_GREEN, 0, "pulse_grant");
    repeat (3) cyc(4'b0000, 0, 0, P_GREEN, 0, "green_min");
    cyc(4'b0000, 0, 0, P_YEL, 0, "min_yel");
    cyc(4'b0000, 0, 0, P_YEL, 0, "min_yel2");
    cyc(4'b0000, 0, 0, P_AR, 0, "min_ar");
    cyc(4'b0000, 0, 0, P_IDLE, 0, "min_idle");

    // M2 alone, request dropped at timer 6.
    cyc(4'b0010, 0, 0, P_GREEN, 1, "m2_grant");
    repeat (6) cyc(4'b0010, 0, 0, P_GREEN, 1, "m2_hold");
    cyc(4'b0000, 0, 0, P_YEL, 1, "m2_yel");
    cyc(4'b0000, 0, 0, P_YEL, 1, "m2_yel2");
    cyc(4'b0000, 0, 0, P_AR, 1, "m2_ar");
    cyc(4'b0000, 0, 0, P_IDLE, 1, "m2_idle");

    // Emergency preemption for S while M1 green at timer 1.
    cyc(4'b0001, 0, 0, P_GREEN, 0, "pre_grant");
    cyc(4'b0001, 0, 0, P_GREEN, 0, "pre_t1");
    cyc(4'b0111, 1, 3, P_YEL, 0, "emg_preempt");
    cyc(4'b0111, 1, 3, P_YEL, 0, "emg_yel2");
    cyc(4'b0111, 1, 3, P_AR, 0, "emg_ar");
    cyc(4'b0111, 1, 3, P_GREEN, 3, "emg_green");
    repeat (12) cyc(4'b0111, 1, 3, P_GREEN, 3, "emg_hold");
    // Redirected emergency behaves like a fresh preemption.
    cyc(4'b0111, 1, 0, P_YEL, 3, "emg_redirect");
    cyc(4'b0111, 1, 0, P_YEL, 3, "redir_yel2");
    cyc(4'b0111, 1, 0, P_AR, 3, "redir_ar");
    cyc(4'b0111, 1, 0, P_GREEN, 0, "redir_green");
    repeat (3) cyc(4'b0000, 0, 0, P_GREEN, 0, "redir_min");
    cyc(4'b0000, 0, 0, P_YEL, 0, "redir_yel");

    // Asynchronous reset in the middle of a yellow.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_phase", {10'd0, phase}, {10'd0, P_IDLE});
    chk("async_rst_gnt", {10'd0, gnt}, 12'd0);
    chk("async_rst_lights", lt, 12'h924);
    @(posedge clk); #1;
    chk("rst_hold_lights", lt, 12'h924);
    rst = 1'b0;

    // Full rotation with every approach requesting.
    for (int a = 0; a < 4; a++) begin
      repeat (8) cyc(4'b1111, 0, 0, P_GREEN, 2'(a), "rr_green");
      repeat (2) cyc(4'b1111, 0, 0, P_YEL, 2'(a), "rr_yel");
      cyc(4'b1111, 0, 0, P_AR, 2'(a), "rr_ar");
    end
    cyc(4'b1111, 0, 0, P_GREEN, 0, "rr_wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
